mem_stage_sram_ctrl: RTL and testbench

- Memory-stage data port on the consuming end of the execution stage.
- Takes the execution result as a byte address, the store value and the memory-enable pair, and performs one 32-bit load or store.
- The access goes to an external 16-bit asynchronous SRAM as two half-word accesses.
- Drives `ready` low while an access is in flight; the pipeline freezes on `ready = 0`.

---
 rtl/mem_stage_sram_ctrl.sv | 118 +++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage data port: performs one 32-bit load or store per request
// as two half-word accesses to an external 16-bit asynchronous SRAM.
// ready stays low while an access is in flight, which freezes the pipeline.
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [31:0]           alu_res,
    input  logic [31:0]           val_rm,
    output logic                  ready,
    output logic [31:0]           read_data,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]           sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [15:0]           sram_dq_in,
    output logic                  sram_we_n
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    state_t                state, nxt;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-2:0] idx_q;
    logic [31:0]           data_q;
    logic [15:0]           lo_q;
    logic [31:0]           off;
    logic                  req;
    logic                  last;
    logic                  unused_off;

    // Byte offset into the SRAM window; only the word index bits matter,
    // sub-word bits and anything above the SRAM size are dropped.
    assign off        = alu_res - BASE_ADDR;
    assign unused_off = ^{off[31:ADDR_WIDTH+1], off[1:0]};
    assign req        = mem_read_en | mem_write_en;
    assign last       = (cnt == '0);

    // State register and per-access captured values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            lo_q      <= '0;
            read_data <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (req) begin
                    idx_q  <= off[ADDR_WIDTH:2];
                    data_q <= val_rm;
                    cnt    <= CNT_INIT;
                end
                RD_LO, RD_HI, WR_LO, WR_HI: cnt <= last ? CNT_INIT : cnt - 1'b1;
                default: ;
            endcase
            // Sample the bus on the final cycle of each read phase; the
            // assembled word lands in read_data as the FSM enters DONE.
            if (state == RD_LO && last) lo_q      <= sram_dq_in;
            if (state == RD_HI && last) read_data <= {sram_dq_in, lo_q};
        end
    end

    // Next-state and SRAM/pipeline outputs, all decoded from the current state
    always_comb begin
        nxt         = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = ~req;
                // write wins when both enables are set
                if (req) nxt = mem_write_en ? WR_LO : RD_LO;
            end
            RD_LO: begin
                sram_addr = {idx_q, 1'b0};
                if (last) nxt = RD_HI;
            end
            RD_HI: begin
                sram_addr = {idx_q, 1'b1};
                if (last) nxt = DONE;
            end
            WR_LO: begin
                sram_addr   = {idx_q, 1'b0};
                sram_dq_out = data_q[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
                if (last) nxt = WR_HI;
            end
            WR_HI: begin
                sram_addr   = {idx_q, 1'b1};
                sram_dq_out = data_q[31:16];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
                if (last) nxt = DONE;
            end
            DONE: begin
                // pipeline advances on this edge; request is not re-sampled
                ready = 1'b1;
                nxt   = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural async SRAM and
// scoreboard queues for expected load results and expected SRAM contents.
module tb_mem_stage_sram_ctrl;

    localparam int AW = 18;
    localparam int W  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read_en, mem_write_en;
    logic [31:0]   alu_res, val_rm;
    logic          ready;
    logic [31:0]   read_data;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;
    logic          sram_dq_oe, sram_we_n;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } mem_exp_t;

    logic [31:0] rd_q[$];
    mem_exp_t    mem_q[$];

    logic [15:0] sram_mem [0:(1<<AW)-1];

    mem_stage_sram_ctrl #(.BASE_ADDR(1024), .ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .alu_res(alu_res), .val_rm(val_rm),
        .ready(ready), .read_data(read_data),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // Async SRAM: combinational read, write captured while we_n is low
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] lo_addr(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return {off[AW:2], 1'b0};
    endfunction

    // One access with enables held until ready; inputs are scrambled mid-access
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] exp_rd);
        logic [15:0]   rdy_m, we_m, oe_m;
        logic [AW-1:0] a1, a4;
        int            done_c;
        rdy_m = '0; we_m = '0; oe_m = '0; a1 = '0; a4 = '0; done_c = -1;
        rd_q.push_back(exp_rd);
        if (wr) begin
            mem_q.push_back('{addr: lo_addr(addr),        data: data[15:0]});
            mem_q.push_back('{addr: lo_addr(addr) | 18'd1, data: data[31:16]});
        end
        @(posedge clk); #1;
        mem_read_en = rd; mem_write_en = wr; alu_res = addr; val_rm = data;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rdy_m[c] = ready;
            we_m[c]  = ~sram_we_n;
            oe_m[c]  = sram_dq_oe;
            if (c == 1) a1 = sram_addr;
            if (c == 4) a4 = sram_addr;
            if (c == 2) begin alu_res = 32'h5555_0000; val_rm = 32'hA5A5_5A5A; end
            if (ready) begin done_c = c; break; end
        end
        chk("latency", 64'(done_c), 64'(2*W+1));
        chk("ready_pattern", 64'(rdy_m), 64'h80);
        chk("we_pattern", 64'(we_m), wr ? 64'h7E : 64'h0);
        chk("oe_pattern", 64'(oe_m), wr ? 64'h7E : 64'h0);
        chk("addr_lo", 64'(a1), 64'(lo_addr(addr)));
        chk("addr_hi", 64'(a4), 64'(lo_addr(addr) | 18'd1));
        chk("read_data", 64'(read_data), 64'(rd_q.pop_front()));
        @(posedge clk); #1;
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        while (mem_q.size() > 0) begin
            mem_exp_t e;
            e = mem_q.pop_front();
            chk("sram_word", 64'(sram_mem[e.addr]), 64'(e.data));
        end
    endtask

    initial begin
        rst = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
        alu_res = '0; val_rm = '0;
        #12;
        chk("rst_outputs", {ready, sram_we_n, sram_dq_oe, 14'(sram_addr), sram_dq_out},
            {1'b1, 1'b1, 1'b0, 14'h0, 16'h0});
        chk("rst_read_data", 64'(read_data), 64'h0);
        @(negedge clk); rst = 1'b1;

        // idle: nothing moves for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {ready, sram_we_n, sram_dq_oe, 32'(sram_addr)}, {1'b1, 1'b1, 1'b0, 32'h0});
        end

        do_access(0, 1, 32'd1028, 32'hDEADBEEF, 32'h0);        // store
        do_access(1, 0, 32'd1028, 32'h0,        32'hDEADBEEF); // load back
        do_access(1, 1, 32'd1032, 32'h12345678, 32'hDEADBEEF); // both -> store
        do_access(1, 0, 32'd1032, 32'h0,        32'h12345678);
        do_access(0, 1, 32'd1020, 32'hCAFEF00D, 32'h12345678); // wraps to top
        chk("wrap_lo", 64'(sram_mem[18'h3FFFE]), 64'hF00D);
        chk("wrap_hi", 64'(sram_mem[18'h3FFFF]), 64'hCAFE);
        do_access(1, 0, 32'd1020, 32'h0,        32'hCAFEF00D);
        do_access(1, 0, 32'd1028, 32'h0,        32'hDEADBEEF);

        // reset in cycle 5 of a load
        @(posedge clk); #1;
        mem_read_en = 1'b1; alu_res = 32'd1028;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_we_n", 64'(sram_we_n), 64'h1);
        chk("midrst_read_data", 64'(read_data), 64'h0);
        mem_read_en = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_idle", {ready, sram_we_n, sram_dq_oe}, {1'b1, 1'b1, 1'b0});
        do_access(1, 0, 32'd1028, 32'h0, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
